// File: rtl/demux_pkg.sv
// Shared widths and the slot word type for the 1-to-8 registered word distributor.
package demux_pkg;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_OUT = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned CNT_W   = 16;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/demux_slot.sv
// One holding register with dirty flag and consumer clear.
// Byte-enable writes are selected by the DEMUX_BYTE_EN macro; otherwise full-word writes.
module demux_slot
  import demux_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  word_t           wr_data,
  input  logic [BE_W-1:0] wr_be,
  input  logic            clr,
  output word_t           data,
  output logic            dirty
);

`ifndef DEMUX_BYTE_EN
  logic unused_be;
  assign unused_be = ^wr_be;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      dirty <= 1'b0;
    end else begin
      if (wr_en) begin
`ifdef DEMUX_BYTE_EN
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (wr_be[i]) data[8*i +: 8] <= wr_data[8*i +: 8];
        end
`else
        data <= wr_data;
`endif
      end
      // A write in the same cycle as a clear leaves the slot dirty.
      if (wr_en)    dirty <= 1'b1;
      else if (clr) dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1t8_32_reg.sv
// Registered 1-to-8 word distributor: select decode, ready mux and accept counter.
// Optional byte-enable writes under the DEMUX_BYTE_EN macro.
module demux1t8_32_reg #(
  parameter int unsigned DATA_W  = demux_pkg::DATA_W,
  parameter int unsigned NUM_OUT = demux_pkg::NUM_OUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [demux_pkg::SEL_W-1:0]   in_sel,
  input  logic [DATA_W-1:0]             in_data,
  input  logic [demux_pkg::BE_W-1:0]    in_be,
  output logic [DATA_W*NUM_OUT-1:0]     out_data,
  output logic [NUM_OUT-1:0]            out_dirty,
  input  logic [NUM_OUT-1:0]            out_clr,
  output logic [demux_pkg::CNT_W-1:0]   acc_cnt
);
  import demux_pkg::*;

  logic               accept;
  logic [NUM_OUT-1:0] dirty;

  assign in_ready  = ~dirty[in_sel];
  assign accept    = in_valid & in_ready;
  assign out_dirty = dirty;

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept && (in_sel == SEL_W'(k))),
      .wr_data (in_data),
      .wr_be   (in_be),
      .clr     (out_clr[k]),
      .data    (out_data[k*DATA_W +: DATA_W]),
      .dirty   (dirty[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc_cnt <= '0;
    else if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_demux1t8_32_reg.sv
// Self-checking bench for demux1t8_32_reg: directed table, sequences, random vs reference model.
module tb_demux1t8_32_reg;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_sel;
  logic [31:0]  in_data;
  logic [3:0]   in_be;
  logic [255:0] out_data;
  logic [7:0]   out_dirty;
  logic [7:0]   out_clr;
  logic [15:0]  acc_cnt;

  int checks = 0;
  int errors = 0;

  demux1t8_32_reg #(.DATA_W(32), .NUM_OUT(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .in_be     (in_be),
    .out_data  (out_data),
    .out_dirty (out_dirty),
    .out_clr   (out_clr),
    .acc_cnt   (acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [3:0]  be;
    logic [7:0]  clr;
    logic        exp_ready;
    logic [7:0]  exp_dirty;
    logic [15:0] exp_cnt;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[9];

  // reference model state
  logic [31:0] m_slot[8];
  logic [7:0]  m_dirty;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_of(input logic [255:0] bus, input int k);
    return bus[k*32 +: 32];
  endfunction

  function automatic logic [255:0] model_bus();
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = m_slot[k];
    return b;
  endfunction

  task automatic idle_inputs();
    in_valid = 1'b0; in_sel = '0; in_data = '0; in_be = '0; out_clr = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_data",  out_data, '0);
    chk("reset_dirty", {248'd0, out_dirty}, '0);
    chk("reset_cnt",   {240'd0, acc_cnt}, '0);
    chk("reset_ready", {255'd0, in_ready}, 256'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) m_slot[k] = '0;
    m_dirty = '0;
    m_cnt   = '0;
  endtask

  // Model step: ready is from current dirty state; clear then write so a write wins.
  task automatic model_step(input logic v, input logic [2:0] s, input logic [31:0] d,
                            input logic [3:0] be, input logic [7:0] c);
    logic rdy;
    rdy = !m_dirty[s];
    m_dirty = m_dirty & ~c;
    if (v && rdy) begin
      for (int b = 0; b < 4; b++) begin
`ifdef DEMUX_BYTE_EN
        if (be[b]) m_slot[s][8*b +: 8] = d[8*b +: 8];
`else
        m_slot[s][8*b +: 8] = d[8*b +: 8];
`endif
      end
      m_dirty[s] = 1'b1;
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  initial begin
    logic [31:0] be_word;
`ifdef DEMUX_BYTE_EN
    be_word = 32'hAA22CC44;
`else
    be_word = 32'h11223344;
`endif
    //          valid sel  data          be     clr    rdy  dirty  cnt  word
    vecs[0] = '{1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 8'h00, 1'b1, 8'h08, 16'd1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 3'd3, 32'h12345678, 4'hF, 8'h00, 1'b0, 8'h08, 16'd1, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 3'd3, 32'h12345678, 4'hF, 8'h08, 1'b0, 8'h00, 16'd1, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 3'd3, 32'h12345678, 4'hF, 8'h00, 1'b1, 8'h08, 16'd2, 32'h12345678};
    vecs[4] = '{1'b1, 3'd1, 32'hAABBCCDD, 4'hF, 8'h00, 1'b1, 8'h0A, 16'd3, 32'hAABBCCDD};
    vecs[5] = '{1'b0, 3'd1, 32'h0,        4'hF, 8'h02, 1'b0, 8'h08, 16'd3, 32'hAABBCCDD};
    vecs[6] = '{1'b1, 3'd1, 32'h11223344, 4'h5, 8'h00, 1'b1, 8'h0A, 16'd4, be_word};
    vecs[7] = '{1'b1, 3'd5, 32'h55555555, 4'hF, 8'h20, 1'b1, 8'h2A, 16'd5, 32'h55555555};
    vecs[8] = '{1'b1, 3'd0, 32'h0BADF00D, 4'hF, 8'h0A, 1'b1, 8'h21, 16'd6, 32'h0BADF00D};

    rst_n = 1'b1;
    idle_inputs();
    #2;
    do_reset();

    // Directed table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = vecs[i].valid; in_sel = vecs[i].sel; in_data = vecs[i].data;
      in_be = vecs[i].be; out_clr = vecs[i].clr;
      #1;
      chk($sformatf("tbl%0d_ready", i), {255'd0, in_ready}, {255'd0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_dirty", i), {248'd0, out_dirty}, {248'd0, vecs[i].exp_dirty});
      chk($sformatf("tbl%0d_cnt", i), {240'd0, acc_cnt}, {240'd0, vecs[i].exp_cnt});
      chk($sformatf("tbl%0d_word", i), {224'd0, slot_of(out_data, int'(vecs[i].sel))},
          {224'd0, vecs[i].exp_word});
      if (i == 0)
        chk("tbl0_others_zero", out_data & ~(256'hFFFFFFFF << 96), '0);
    end

    // Back-to-back writes to every slot, one per cycle
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = 3'(k); in_data = 32'h11111111 * k; in_be = 4'hF; out_clr = '0;
      #1;
      chk($sformatf("b2b_ready%0d", k), {255'd0, in_ready}, 256'd1);
    end
    @(posedge clk);
    #1;
    chk("b2b_dirty", {248'd0, out_dirty}, 256'hFF);
    chk("b2b_cnt",   {240'd0, acc_cnt}, 256'd8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("b2b_slot%0d", k), {224'd0, slot_of(out_data, k)}, {224'd0, 32'h11111111 * k});

    // Asynchronous reset in the middle of a cycle with a write pending
    @(negedge clk);
    out_clr = 8'h01; in_sel = 3'd0; in_valid = 1'b1; in_data = 32'hCAFEF00D;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_data",  out_data, '0);
    chk("midrst_dirty", {248'd0, out_dirty}, '0);
    chk("midrst_cnt",   {240'd0, acc_cnt}, '0);
    chk("midrst_ready", {255'd0, in_ready}, 256'd1);
    @(posedge clk);
    #1;
    chk("midrst_hold", out_data, '0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic       v;
      logic [2:0] s;
      logic [31:0] d;
      logic [3:0] be;
      logic [7:0] c;
      v  = ($urandom_range(0, 3) != 0);
      s  = 3'($urandom_range(0, 7));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      c  = 8'($urandom) & 8'($urandom);
      @(negedge clk);
      in_valid = v; in_sel = s; in_data = d; in_be = be; out_clr = c;
      #1;
      chk("rnd_ready", {255'd0, in_ready}, {255'd0, !m_dirty[s]});
      model_step(v, s, d, be, c);
      @(posedge clk);
      #1;
      chk("rnd_data",  out_data, model_bus());
      chk("rnd_dirty", {248'd0, out_dirty}, {248'd0, m_dirty});
      chk("rnd_cnt",   {240'd0, acc_cnt}, {240'd0, m_cnt});
    end

    // Counter wrap: keep writing rotating slots while clearing all others
    do_reset();
    begin
      int stalls = 0;
      for (int n = 0; n < 65535; n++) begin
        @(negedge clk);
        in_valid = 1'b1; in_sel = 3'(n % 8); in_data = n; in_be = 4'hF;
        out_clr = ~(8'd1 << (n % 8));
        #1;
        if (!in_ready) stalls++;
      end
      chk("wrap_no_stall", stalls, 0);
    end
    @(posedge clk);
    #1;
    chk("wrap_cnt_max", {240'd0, acc_cnt}, 256'hFFFF);
    @(negedge clk);
    in_sel = 3'd7; out_clr = 8'h7F; // slot 7 was last written 8 cycles ago and cleared since
    @(posedge clk);
    #1;
    chk("wrap_cnt_zero", {240'd0, acc_cnt}, '0);
    @(negedge clk);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
